hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 143 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for an in-order pipeline with a multicycle mul/div unit.
// Tracks per-register result countdowns, detects RAW/WAW/structural/load-use
// and branch-operand hazards in ID, and drives the pipeline stall/flush controls.
module hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int MUL_LAT  = 4,
    parameter int STALL_CW = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [REG_AW-1:0]   id_rs,
    input  logic [REG_AW-1:0]   id_rt,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic [REG_AW-1:0]   id_dest,
    input  logic                id_regwrite,
    input  logic                id_is_mul,
    input  logic                id_is_branch,
    input  logic                idex_memread,
    input  logic                idex_regwrite,
    input  logic [REG_AW-1:0]   idex_rd,
    input  logic                exmem_memread,
    input  logic [REG_AW-1:0]   exmem_rd,
    input  logic                branch_taken,
    input  logic                jump,
    output logic                pc_write,
    output logic                ifid_write,
    output logic                bubble_idex,
    output logic                flush_ifid,
    output logic                mul_busy,
    output logic [STALL_CW-1:0] stall_cycles
);

    localparam int NREG = 1 << REG_AW;
    localparam int SBW  = $clog2(MUL_LAT + 1);
    localparam logic [SBW-1:0]      SB_LOAD   = SBW'(MUL_LAT);
    localparam logic [SBW-1:0]      BUSY_LOAD = SBW'(MUL_LAT - 1);
    localparam logic [SBW-1:0]      SB_ONE    = SBW'(1);
    localparam logic [STALL_CW-1:0] CNT_ONE   = STALL_CW'(1);

    logic [SBW-1:0]      sb_r [NREG];
    logic [SBW-1:0]      busy_cnt_r;
    logic [STALL_CW-1:0] stall_cycles_r;

    logic raw_s, waw_s, struct_s, load_use_s, br_ex_s, br_mem_s;
    logic stall_s, mul_issue_s, sb_load_s;

    // A producer register rd feeds the ID instruction if it is nonzero and matches a used source.
    function automatic logic src_hit(input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs,
                                     input logic [REG_AW-1:0] rt,
                                     input logic              use_rs,
                                     input logic              use_rt);
        return (rd != '0) && ((use_rs && (rd == rs)) || (use_rt && (rd == rt)));
    endfunction

    // Hazard detection; sb==1 means the result is forwarded next cycle, so only >1 stalls.
    always_comb begin
        raw_s      = 1'b0;
        waw_s      = 1'b0;
        struct_s   = 1'b0;
        load_use_s = 1'b0;
        br_ex_s    = 1'b0;
        br_mem_s   = 1'b0;
        raw_s      = (id_use_rs && (sb_r[id_rs] > SB_ONE)) ||
                     (id_use_rt && (sb_r[id_rt] > SB_ONE));
        waw_s      = id_regwrite && (id_dest != '0) && (sb_r[id_dest] != '0);
        struct_s   = id_is_mul && mul_busy;
        load_use_s = idex_memread && src_hit(idex_rd, id_rs, id_rt, id_use_rs, id_use_rt);
        br_ex_s    = id_is_branch && idex_regwrite &&
                     src_hit(idex_rd, id_rs, id_rt, id_use_rs, id_use_rt);
        br_mem_s   = id_is_branch && exmem_memread &&
                     src_hit(exmem_rd, id_rs, id_rt, id_use_rs, id_use_rt);
    end

    assign stall_s     = id_valid && (raw_s || waw_s || struct_s || load_use_s || br_ex_s || br_mem_s);
    assign mul_issue_s = id_valid && !stall_s && id_is_mul;
    assign sb_load_s   = mul_issue_s && id_regwrite && (id_dest != '0);
    assign mul_busy    = (busy_cnt_r != '0);
    assign stall_cycles = stall_cycles_r;

    // Pipeline control: stall overrides any redirect; a redirect flushes the fetched instruction.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        bubble_idex = 1'b0;
        flush_ifid  = 1'b0;
        if (stall_s) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            bubble_idex = 1'b1;
        end else if (branch_taken || jump) begin
            flush_ifid  = 1'b1;
        end else begin
            flush_ifid  = 1'b0;
        end
    end

    // Per-register result countdown; a new issue reloads ahead of the decrement, r0 never pends.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) sb_r[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (r == 0) begin
                    sb_r[r] <= '0;
                end else if (sb_load_s && (id_dest == REG_AW'(r))) begin
                    sb_r[r] <= SB_LOAD;
                end else if (sb_r[r] != '0) begin
                    sb_r[r] <= sb_r[r] - SB_ONE;
                end else begin
                    sb_r[r] <= sb_r[r];
                end
            end
        end
    end

    // Multicycle unit occupancy, loaded on every mul issue regardless of destination.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_cnt_r <= '0;
        end else if (mul_issue_s) begin
            busy_cnt_r <= BUSY_LOAD;
        end else if (busy_cnt_r != '0) begin
            busy_cnt_r <= busy_cnt_r - SB_ONE;
        end else begin
            busy_cnt_r <= busy_cnt_r;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cycles_r <= '0;
        end else if (stall_s && (stall_cycles_r != '1)) begin
            stall_cycles_r <= stall_cycles_r + CNT_ONE;
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed pipeline scenarios plus
// randomized traffic checked against a cycle-timestamp reference model.
module tb_hazard_scoreboard;

    localparam int REG_AW   = 5;
    localparam int MUL_LAT  = 4;
    localparam int STALL_CW = 16;
    localparam int NREG     = 1 << REG_AW;
    localparam logic [STALL_CW-1:0] ALL1 = '1;
    localparam logic [3:0] C_RUN   = 4'b1100; // {pc_write, ifid_write, bubble_idex, flush_ifid}
    localparam logic [3:0] C_STALL = 4'b0010;
    localparam logic [3:0] C_FLUSH = 4'b1101;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic id_valid, id_use_rs, id_use_rt, id_regwrite, id_is_mul, id_is_branch;
    logic [REG_AW-1:0] id_rs, id_rt, id_dest, idex_rd, exmem_rd;
    logic idex_memread, idex_regwrite, exmem_memread, branch_taken, jump;
    logic pc_write, ifid_write, bubble_idex, flush_ifid, mul_busy;
    logic [STALL_CW-1:0] stall_cycles;
    logic [3:0] ctrl;

    int checks = 0;
    int fails  = 0;

    // Reference model: cycle at which each register's result is fully written, and mul-unit free cycle.
    int m_ready [NREG];
    int m_busy_end;
    int m_now;

    hazard_scoreboard #(.REG_AW(REG_AW), .MUL_LAT(MUL_LAT), .STALL_CW(STALL_CW)) dut (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_dest(id_dest), .id_regwrite(id_regwrite), .id_is_mul(id_is_mul),
        .id_is_branch(id_is_branch), .idex_memread(idex_memread),
        .idex_regwrite(idex_regwrite), .idex_rd(idex_rd),
        .exmem_memread(exmem_memread), .exmem_rd(exmem_rd),
        .branch_taken(branch_taken), .jump(jump),
        .pc_write(pc_write), .ifid_write(ifid_write), .bubble_idex(bubble_idex),
        .flush_ifid(flush_ifid), .mul_busy(mul_busy), .stall_cycles(stall_cycles)
    );

    assign ctrl = {pc_write, ifid_write, bubble_idex, flush_ifid};

    always #5 clock = ~clock;

    task automatic idle();
        id_valid = 1'b0; id_use_rs = 1'b0; id_use_rt = 1'b0; id_regwrite = 1'b0;
        id_is_mul = 1'b0; id_is_branch = 1'b0; id_rs = '0; id_rt = '0; id_dest = '0;
        idex_memread = 1'b0; idex_regwrite = 1'b0; idex_rd = '0;
        exmem_memread = 1'b0; exmem_rd = '0; branch_taken = 1'b0; jump = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Present a register-writing instruction in ID.
    task automatic instr(input logic mul, input int dest, input logic urs, input int rs,
                         input logic urt, input int rt);
        idle();
        id_valid = 1'b1; id_is_mul = mul; id_regwrite = 1'b1; id_dest = REG_AW'(dest);
        id_use_rs = urs; id_rs = REG_AW'(rs); id_use_rt = urt; id_rt = REG_AW'(rt);
    endtask

    function automatic int remain(input int r);
        if (r == 0 || m_ready[r] <= m_now) return 0;
        return m_ready[r] - m_now;
    endfunction

    function automatic logic hits(input int r);
        return (r != 0) && ((id_use_rs && int'(id_rs) == r) || (id_use_rt && int'(id_rt) == r));
    endfunction

    task automatic test_reset();
        idle();
        reset = 1'b0;
        #1;
        checks++;
        if (stall_cycles !== '0) begin fails++; $display("FAIL reset_stall_cycles got %0d want 0", stall_cycles); end
        checks++;
        if (mul_busy !== 1'b0) begin fails++; $display("FAIL reset_mul_busy got %b want 0", mul_busy); end
        checks++;
        if (ctrl !== C_RUN) begin fails++; $display("FAIL reset_ctrl got %b want %b", ctrl, C_RUN); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    // mul r5, one independent instruction, then ADD reading r5: sees sb=3,2 (stall) then 1 (issue).
    task automatic test_mul_raw();
        do_reset();
        instr(1'b1, 5, 1'b1, 1, 1'b1, 2); #1;
        checks++;
        if (ctrl !== C_RUN) begin fails++; $display("FAIL raw_mul_issue got %b want %b", ctrl, C_RUN); end
        step();
        instr(1'b0, 6, 1'b1, 1, 1'b1, 2); #1;
        checks++;
        if (ctrl !== C_RUN) begin fails++; $display("FAIL raw_indep got %b want %b", ctrl, C_RUN); end
        step();
        instr(1'b0, 6, 1'b1, 5, 1'b0, 0);
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (ctrl !== C_STALL) begin fails++; $display("FAIL raw_stall%0d got %b want %b", k, ctrl, C_STALL); end
            step();
        end
        #1;
        checks++;
        if (ctrl !== C_RUN) begin fails++; $display("FAIL raw_release got %b want %b", ctrl, C_RUN); end
        checks++;
        if (stall_cycles !== 16'd2) begin fails++; $display("FAIL raw_stall_cycles got %0d want 2", stall_cycles); end
        step();
    endtask

    task automatic test_load_use();
        do_reset();
        instr(1'b0, 4, 1'b1, 1, 1'b1, 3);
        idex_memread = 1'b1; idex_rd = 5'd3; #1;
        checks++;
        if (ctrl !== C_STALL) begin fails++; $display("FAIL lu_stall got %b want %b", ctrl, C_STALL); end
        step();
        idex_memread = 1'b0; idex_rd = '0; exmem_memread = 1'b1; exmem_rd = 5'd3; #1;
        checks++;
        if (ctrl !== C_RUN) begin fails++; $display("FAIL lu_release got %b want %b", ctrl, C_RUN); end
        step();
        idle(); #1;
        checks++;
        if (stall_cycles !== 16'd1) begin fails++; $display("FAIL lu_stall_cycles got %0d want 1", stall_cycles); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        instr(1'b1, 7, 1'b0, 0, 1'b0, 0); #1;
        checks++;
        if (ctrl !== C_RUN) begin fails++; $display("FAIL b2b_first got %b want %b", ctrl, C_RUN); end
        step();
        instr(1'b1, 8, 1'b0, 0, 1'b0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if ({ctrl, mul_busy} !== {C_STALL, 1'b1}) begin
                fails++; $display("FAIL b2b_stall%0d got %b/%b want %b/1", k, ctrl, mul_busy, C_STALL);
            end
            step();
        end
        #1;
        checks++;
        if ({ctrl, mul_busy} !== {C_RUN, 1'b0}) begin
            fails++; $display("FAIL b2b_release got %b/%b want %b/0", ctrl, mul_busy, C_RUN);
        end
        step();
        idle(); #1;
        checks++;
        if ({mul_busy, stall_cycles} !== {1'b1, 16'd3}) begin
            fails++; $display("FAIL b2b_second got busy=%b cnt=%0d want busy=1 cnt=3", mul_busy, stall_cycles);
        end
    endtask

    task automatic test_branch();
        do_reset();
        idle();
        id_valid = 1'b1; id_is_branch = 1'b1; id_use_rs = 1'b1; id_rs = 5'd4;
        id_use_rt = 1'b1; id_rt = 5'd2; branch_taken = 1'b1;
        idex_regwrite = 1'b1; idex_rd = 5'd4; #1;
        checks++;
        if (ctrl !== C_STALL) begin fails++; $display("FAIL br_stall got %b want %b", ctrl, C_STALL); end
        step();
        idex_regwrite = 1'b0; idex_rd = '0; exmem_rd = 5'd4; #1;
        checks++;
        if (ctrl !== C_FLUSH) begin fails++; $display("FAIL br_flush got %b want %b", ctrl, C_FLUSH); end
        step();
        idle(); id_valid = 1'b1; jump = 1'b1; #1;
        checks++;
        if (ctrl !== C_FLUSH) begin fails++; $display("FAIL jump_flush got %b want %b", ctrl, C_FLUSH); end
        step();
    endtask

    task automatic test_mul_r0();
        do_reset();
        instr(1'b1, 0, 1'b0, 0, 1'b0, 0); #1;
        step();
        instr(1'b0, 1, 1'b1, 0, 1'b1, 0); #1;
        checks++;
        if ({ctrl, mul_busy} !== {C_RUN, 1'b1}) begin
            fails++; $display("FAIL r0_no_raw got %b/%b want %b/1", ctrl, mul_busy, C_RUN);
        end
        step();
    endtask

    task automatic test_saturate_reset();
        do_reset();
        instr(1'b0, 4, 1'b0, 0, 1'b1, 3);
        idex_memread = 1'b1; idex_rd = 5'd3;
        repeat ((1 << STALL_CW) + 3) step();
        #1;
        checks++;
        if (stall_cycles !== ALL1) begin fails++; $display("FAIL sat_value got %0d want %0d", stall_cycles, ALL1); end
        idle(); step(); #1;
        checks++;
        if (stall_cycles !== ALL1) begin fails++; $display("FAIL sat_hold got %0d want %0d", stall_cycles, ALL1); end
        instr(1'b1, 9, 1'b0, 0, 1'b0, 0); #1;
        step();
        idle(); #1;
        checks++;
        if (mul_busy !== 1'b1) begin fails++; $display("FAIL pend_busy got %b want 1", mul_busy); end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({mul_busy, stall_cycles} !== {1'b0, 16'd0}) begin
            fails++; $display("FAIL midreset_clear got busy=%b cnt=%0d want 0/0", mul_busy, stall_cycles);
        end
        @(negedge clock);
        reset = 1'b1;
        instr(1'b1, 9, 1'b1, 9, 1'b1, 9); #1;
        checks++;
        if (ctrl !== C_RUN) begin fails++; $display("FAIL post_reset_nostall got %b want %b", ctrl, C_RUN); end
        step();
        idle();
    endtask

    task automatic test_random();
        int rr_s, rr_t;
        logic exp_stall, hz;
        logic [3:0] exp_ctrl;
        int exp_cnt;
        do_reset();
        for (int r = 0; r < NREG; r++) m_ready[r] = 0;
        m_busy_end = 0; m_now = 0; exp_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            id_valid      = ($urandom_range(0, 9) < 8);
            id_is_mul     = ($urandom_range(0, 9) < 3);
            id_regwrite   = ($urandom_range(0, 9) < 8);
            id_is_branch  = ($urandom_range(0, 9) < 2);
            id_use_rs     = $urandom_range(0, 1);
            id_use_rt     = $urandom_range(0, 1);
            id_rs         = REG_AW'($urandom_range(0, 7));
            id_rt         = REG_AW'($urandom_range(0, 7));
            id_dest       = REG_AW'($urandom_range(0, 7));
            idex_memread  = ($urandom_range(0, 9) < 2);
            idex_regwrite = $urandom_range(0, 1);
            idex_rd       = REG_AW'($urandom_range(0, 7));
            exmem_memread = ($urandom_range(0, 9) < 3);
            exmem_rd      = REG_AW'($urandom_range(0, 7));
            branch_taken  = ($urandom_range(0, 9) < 2);
            jump          = ($urandom_range(0, 19) < 1);
            #1;
            rr_s = int'(id_rs); rr_t = int'(id_rt);
            hz = (id_use_rs && remain(rr_s) > 1) || (id_use_rt && remain(rr_t) > 1) ||
                 (id_regwrite && remain(int'(id_dest)) > 0) ||
                 (id_is_mul && m_now < m_busy_end) ||
                 (idex_memread && hits(int'(idex_rd))) ||
                 (id_is_branch && idex_regwrite && hits(int'(idex_rd))) ||
                 (id_is_branch && exmem_memread && hits(int'(exmem_rd)));
            exp_stall = id_valid && hz;
            exp_ctrl  = exp_stall ? C_STALL : ((branch_taken || jump) ? C_FLUSH : C_RUN);
            checks++;
            if (ctrl !== exp_ctrl) begin fails++; $display("FAIL rnd_ctrl cyc%0d got %b want %b", i, ctrl, exp_ctrl); end
            checks++;
            if (mul_busy !== (m_now < m_busy_end)) begin
                fails++; $display("FAIL rnd_busy cyc%0d got %b want %b", i, mul_busy, (m_now < m_busy_end));
            end
            checks++;
            if (int'(stall_cycles) !== exp_cnt) begin
                fails++; $display("FAIL rnd_cnt cyc%0d got %0d want %0d", i, stall_cycles, exp_cnt);
            end
            if (exp_stall && exp_cnt < (1 << STALL_CW) - 1) exp_cnt++;
            if (id_valid && !exp_stall && id_is_mul) begin
                m_busy_end = m_now + MUL_LAT;
                if (id_regwrite && id_dest != '0) m_ready[int'(id_dest)] = m_now + MUL_LAT + 1;
            end
            step();
            m_now++;
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_mul_raw();
        test_load_use();
        test_back_to_back();
        test_branch();
        test_mul_r0();
        test_random();
        test_saturate_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
